// File: rtl/uart_loopback_fifo.sv
// Byte FIFO between uart_rx and uart_tx: level-handshake receive side, request/idle
// transmit side, occupancy count and a sticky overflow flag for dropped bytes.
module uart_loopback_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_data_available,
    output logic                  rx_clear,
    input  logic                  tx_idle,
    output logic                  tx_request,
    output logic [7:0]            tx_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  clear_overflow
);

    localparam int                  DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    typedef enum logic {R_IDLE = 1'b0, R_ACK = 1'b1} rx_state_t;
    typedef enum logic [1:0] {T_IDLE = 2'd0, T_REQ = 2'd1, T_BUSY = 2'd2} tx_state_t;

    rx_state_t             rx_state_r, rx_state_next_s;
    tx_state_t             tx_state_r, tx_state_next_s;
    logic [7:0]            mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_r, rd_ptr_r;
    logic [DEPTH_LOG2:0]   count_r;
    logic                  overflow_r, rx_clear_r, tx_request_r;
    logic                  rx_clear_next_s, tx_request_next_s;
    logic [7:0]            tx_data_r;
    logic                  full_s, empty_s, write_s, drop_s, pop_s;

    // Fullness and emptiness always use the count from before this cycle's write/pop.
    assign full_s  = (count_r == FULL_COUNT);
    assign empty_s = (count_r == {(DEPTH_LOG2 + 1){1'b0}});

    // Receive FSM: one write or one drop per rx_data_available assertion.
    always_comb begin
        rx_state_next_s = rx_state_r;
        rx_clear_next_s = rx_clear_r;
        write_s         = 1'b0;
        drop_s          = 1'b0;
        case (rx_state_r)
            R_IDLE: begin
                if (rx_data_available) begin
                    write_s         = ~full_s;
                    drop_s          = full_s;
                    rx_clear_next_s = 1'b1;
                    rx_state_next_s = R_ACK;
                end else begin
                    rx_clear_next_s = 1'b0;
                end
            end
            R_ACK: begin
                if (!rx_data_available) begin
                    rx_clear_next_s = 1'b0;
                    rx_state_next_s = R_IDLE;
                end else begin
                    rx_clear_next_s = 1'b1;
                end
            end
            default: begin
                rx_clear_next_s = 1'b0;
                rx_state_next_s = R_IDLE;
            end
        endcase
    end

    // Transmit FSM: pop on launch, hold request until the transmitter goes busy.
    always_comb begin
        tx_state_next_s   = tx_state_r;
        tx_request_next_s = tx_request_r;
        pop_s             = 1'b0;
        case (tx_state_r)
            T_IDLE: begin
                if (!empty_s && tx_idle) begin
                    pop_s             = 1'b1;
                    tx_request_next_s = 1'b1;
                    tx_state_next_s   = T_REQ;
                end else begin
                    tx_request_next_s = 1'b0;
                end
            end
            T_REQ: begin
                if (!tx_idle) begin
                    tx_request_next_s = 1'b0;
                    tx_state_next_s   = T_BUSY;
                end else begin
                    tx_request_next_s = 1'b1;
                end
            end
            T_BUSY: begin
                tx_request_next_s = 1'b0;
                if (tx_idle) begin
                    tx_state_next_s = T_IDLE;
                end else begin
                    tx_state_next_s = T_BUSY;
                end
            end
            default: begin
                tx_request_next_s = 1'b0;
                tx_state_next_s   = T_IDLE;
            end
        endcase
    end

    // State, handshake outputs, pointers, occupancy and overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_r   <= R_IDLE;
            tx_state_r   <= T_IDLE;
            rx_clear_r   <= 1'b0;
            tx_request_r <= 1'b0;
            tx_data_r    <= 8'h00;
            wr_ptr_r     <= {DEPTH_LOG2{1'b0}};
            rd_ptr_r     <= {DEPTH_LOG2{1'b0}};
            count_r      <= {(DEPTH_LOG2 + 1){1'b0}};
            overflow_r   <= 1'b0;
        end else begin
            rx_state_r   <= rx_state_next_s;
            tx_state_r   <= tx_state_next_s;
            rx_clear_r   <= rx_clear_next_s;
            tx_request_r <= tx_request_next_s;
            if (write_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                tx_data_r <= mem_r[rd_ptr_r];
                rd_ptr_r  <= rd_ptr_r + PTR_ONE;
            end else begin
                tx_data_r <= tx_data_r;
                rd_ptr_r  <= rd_ptr_r;
            end
            case ({write_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            // A drop in the same cycle as a clear request keeps the flag set.
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (clear_overflow) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (write_s) begin
            mem_r[wr_ptr_r] <= rx_data;
        end
    end

    assign rx_clear   = rx_clear_r;
    assign tx_request = tx_request_r;
    assign tx_data    = tx_data_r;
    assign count      = count_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_uart_loopback_fifo.sv
// Directed bench for uart_loopback_fifo: handshakes, ordering, overflow, push/pop
// collision with pointer wrap, and asynchronous reset in the middle of a transfer.
module tb_uart_loopback_fifo;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_data_available;
    logic       rx_clear;
    logic       tx_idle;
    logic       tx_request;
    logic [7:0] tx_data;
    logic [4:0] count;
    logic       overflow;
    logic       clear_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    uart_loopback_fifo #(.DEPTH_LOG2(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rx_data           (rx_data),
        .rx_data_available (rx_data_available),
        .rx_clear          (rx_clear),
        .tx_idle           (tx_idle),
        .tx_request        (tx_request),
        .tx_data           (tx_data),
        .count             (count),
        .overflow          (overflow),
        .clear_overflow    (clear_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One receive handshake: raise available, see rx_clear, drop available.
    task automatic send_byte(input logic [7:0] b);
        rx_data           = b;
        rx_data_available = 1'b1;
        step(1);
        chk("rx_clear_rise", 32'(rx_clear), 32'd1);
        rx_data_available = 1'b0;
        step(1);
        chk("rx_clear_fall", 32'(rx_clear), 32'd0);
    endtask

    task automatic wait_req(input string tag);
        int k;
        k = 0;
        while (tx_request !== 1'b1 && k < 20) begin
            step(1);
            k++;
        end
        chk(tag, 32'(tx_request), 32'd1);
    endtask

    // Transmitter model: go idle, take one byte, go busy (leaves tx_idle low).
    task automatic accept_byte(input logic [7:0] exp);
        tx_idle = 1'b1;
        wait_req("tx_request_wait");
        chk("tx_data", 32'(tx_data), 32'(exp));
        tx_idle = 1'b0;
        step(1);
        chk("tx_request_drop", 32'(tx_request), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n             = 1'b0;
        rx_data           = 8'h00;
        rx_data_available = 1'b0;
        tx_idle           = 1'b1;
        clear_overflow    = 1'b0;
        step(3);
        chk("reset_rx_clear", 32'(rx_clear), 32'd0);
        chk("reset_tx_request", 32'(tx_request), 32'd0);
        chk("reset_tx_data", 32'(tx_data), 32'd0);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        step(2);
        chk("idle_no_request", 32'(tx_request), 32'd0);

        // Single byte, empty FIFO, idle transmitter.
        rx_data           = 8'hA5;
        rx_data_available = 1'b1;
        step(1);
        chk("t1_rx_clear_1cyc", 32'(rx_clear), 32'd1);
        chk("t1_req_not_yet", 32'(tx_request), 32'd0);
        chk("t1_count_written", 32'(count), 32'd1);
        step(1);
        chk("t1_rx_clear_held", 32'(rx_clear), 32'd1);
        chk("t1_req_2cyc", 32'(tx_request), 32'd1);
        chk("t1_tx_data", 32'(tx_data), 32'hA5);
        chk("t1_count_popped", 32'(count), 32'd0);
        rx_data_available = 1'b0;
        step(1);
        chk("t1_rx_clear_drop", 32'(rx_clear), 32'd0);
        chk("t1_req_hold", 32'(tx_request), 32'd1);
        tx_idle = 1'b0;
        step(1);
        chk("t1_req_drop", 32'(tx_request), 32'd0);
        chk("t1_count_zero", 32'(count), 32'd0);
        tx_idle = 1'b1;
        step(1);

        // Burst ordering with a busy transmitter.
        tx_idle = 1'b0;
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        chk("t2_count5", 32'(count), 32'd5);
        chk("t2_no_req_busy", 32'(tx_request), 32'd0);
        for (int i = 1; i <= 5; i++) accept_byte(8'(i));
        chk("t2_count0", 32'(count), 32'd0);

        // Fill to 16, the 17th byte is dropped.
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        chk("t3_count16", 32'(count), 32'd16);
        chk("t3_no_overflow_yet", 32'(overflow), 32'd0);
        send_byte(8'h10);
        chk("t3_count_still16", 32'(count), 32'd16);
        chk("t3_overflow_set", 32'(overflow), 32'd1);
        clear_overflow = 1'b1;
        step(1);
        clear_overflow = 1'b0;
        chk("t3_overflow_cleared", 32'(overflow), 32'd0);

        // Drop and clear in the same cycle: the drop wins.
        rx_data           = 8'h77;
        rx_data_available = 1'b1;
        clear_overflow    = 1'b1;
        step(1);
        clear_overflow    = 1'b0;
        rx_data_available = 1'b0;
        chk("t5_set_wins", 32'(overflow), 32'd1);
        chk("t5_count16", 32'(count), 32'd16);
        step(1);
        clear_overflow = 1'b1;
        step(1);
        clear_overflow = 1'b0;
        chk("t5_cleared", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) accept_byte(8'(i));
        chk("t3_drained", 32'(count), 32'd0);

        // Walk both pointers (now at 6) up to entry 15.
        for (int i = 0; i < 9; i++) send_byte(8'(8'h40 + i));
        for (int i = 0; i < 9; i++) accept_byte(8'(8'h40 + i));
        send_byte(8'h5A);
        chk("t4_count1", 32'(count), 32'd1);
        tx_idle = 1'b1;
        step(1);
        // Pop of entry 15 and write of entry 0 on the same edge.
        rx_data           = 8'hC3;
        rx_data_available = 1'b1;
        step(1);
        chk("t4_count_stays1", 32'(count), 32'd1);
        chk("t4_req", 32'(tx_request), 32'd1);
        chk("t4_tx_data_wrap", 32'(tx_data), 32'h5A);
        chk("t4_rx_clear", 32'(rx_clear), 32'd1);
        rx_data_available = 1'b0;
        tx_idle           = 1'b0;
        step(1);
        chk("t4_req_drop", 32'(tx_request), 32'd0);
        accept_byte(8'hC3);
        chk("t4_count0", 32'(count), 32'd0);

        // Asynchronous reset while in T_REQ with three bytes stored.
        for (int i = 0; i < 4; i++) send_byte(8'(8'h90 + i));
        tx_idle = 1'b1;
        wait_req("t6_req_before_reset");
        chk("t6_count3", 32'(count), 32'd3);
        chk("t6_tx_data", 32'(tx_data), 32'h90);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_req", 32'(tx_request), 32'd0);
        chk("t6_async_rx_clear", 32'(rx_clear), 32'd0);
        chk("t6_async_count", 32'(count), 32'd0);
        chk("t6_async_tx_data", 32'(tx_data), 32'd0);
        step(2);
        rst_n = 1'b1;
        step(5);
        chk("t6_no_req_after_release", 32'(tx_request), 32'd0);
        chk("t6_count_after_release", 32'(count), 32'd0);
        send_byte(8'h3C);
        wait_req("t6_req_new_byte");
        chk("t6_new_byte", 32'(tx_data), 32'h3C);
        tx_idle = 1'b0;
        step(1);
        chk("t6_final_count", 32'(count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
